// File: rtl/clock_divider_bank_if.sv
// rtl/clock_divider_bank_if.sv - control and output bundle for the clock divider bank
interface clock_divider_bank_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 32,
   parameter int LCH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
   logic [CHANNELS-1:0] en;
   logic [CHANNELS-1:0] mode;
   logic                load;
   logic [LCH_W-1:0]    load_ch;
   logic [CNT_W-1:0]    load_div;
   logic                sync;
   logic [CHANNELS-1:0] clk_out;
   logic [CHANNELS-1:0] tick;

   modport master (
      output en, mode, load, load_ch, load_div, sync,
      input  clk_out, tick
   );

   modport slave (
      input  en, mode, load, load_ch, load_div, sync,
      output clk_out, tick
   );
endinterface

// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - multi-channel programmable clock divider and tick generator
module clock_divider_bank #(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 32,
   parameter int DEFAULT_DIV = 25000000
) (
   input  logic                 CLKin,
   input  logic                 clr,
   clock_divider_bank_if.slave  bus
);
   localparam int               LCH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [LCH_W:0]   CH_LIM = CHANNELS[LCH_W:0];
   localparam logic [CNT_W-1:0] DEF    = CNT_W'(DEFAULT_DIV);

   logic ch_ok;
   assign ch_ok = ({1'b0, bus.load_ch} < CH_LIM);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] shd;
      logic             pnd;
      logic             out_q;
      logic             tick_q;
      logic             hit;
      logic [CNT_W-1:0] shd_n;
      logic             pnd_n;

      assign hit   = bus.load && ch_ok && (bus.load_ch == LCH_W'(i));
      assign shd_n = hit ? bus.load_div : shd;
      assign pnd_n = hit | pnd;

      always_ff @(posedge CLKin) begin
         if (clr) begin
            cnt    <= '0;
            div    <= DEF;
            shd    <= DEF;
            pnd    <= 1'b0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            shd <= shd_n;
            pnd <= pnd_n;
            if (bus.sync) begin
               // a load arriving with sync is the value that takes effect
               cnt    <= '0;
               out_q  <= 1'b0;
               tick_q <= 1'b0;
               if (pnd_n) begin
                  div <= shd_n;
                  pnd <= 1'b0;
               end
            end else if (!bus.en[i]) begin
               tick_q <= 1'b0;
               if (bus.mode[i])
                  out_q <= 1'b0;
               if (pnd) begin
                  div <= shd;
                  pnd <= hit;
                  if (cnt > shd)
                     cnt <= '0;
               end
            end else if (cnt == div) begin
               cnt    <= '0;
               tick_q <= 1'b1;
               out_q  <= bus.mode[i] ? 1'b1 : ~out_q;
               // only a load already registered before this edge swaps the period
               if (pnd) begin
                  div <= shd;
                  pnd <= hit;
               end
            end else begin
               cnt    <= cnt + CNT_W'(1);
               tick_q <= 1'b0;
               if (bus.mode[i])
                  out_q <= 1'b0;
            end
         end
      end

      assign bus.clk_out[i] = out_q;
      assign bus.tick[i]    = tick_q;
   end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb/tb_clock_divider_bank.sv - self-checking bench for clock_divider_bank
module tb_clock_divider_bank;
   logic CLKin = 1'b0;
   logic clr;
   int   total = 0;
   int   bad   = 0;
   logic [3:0] exp_q[$];

   always #5 CLKin = ~CLKin;

   clock_divider_bank_if #(.CHANNELS(2), .CNT_W(8)) bus ();

   clock_divider_bank #(.CHANNELS(2), .CNT_W(8), .DEFAULT_DIV(3)) dut (
      .CLKin (CLKin),
      .clr   (clr),
      .bus   (bus)
   );

   // {clk_out, tick} of a div=3 toggle channel j edges after clr release
   function automatic logic [1:0] tog4(input int j);
      return {((j / 4) % 2) == 1, (j > 0) && (j % 4 == 0)};
   endfunction

   task automatic idle_inputs();
      bus.load     = 1'b0;
      bus.load_ch  = '0;
      bus.load_div = '0;
      bus.sync     = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      idle_inputs();
      bus.en   = 2'b00;
      bus.mode = 2'b00;
      repeat (2) @(posedge CLKin);
      #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] got, want;
      clr          = 1'b1;
      bus.en       = 2'b11;
      bus.mode     = 2'b00;
      bus.load     = 1'b1;
      bus.load_ch  = 1'b0;
      bus.load_div = 8'd9;
      bus.sync     = 1'b1;
      exp_q.push_back(4'b0000);
      repeat (2) @(posedge CLKin);
      #1;
      got  = {bus.clk_out, bus.tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL reset got=%b want=%b", got, want);
      end
   endtask

   task automatic test_toggle();
      logic [3:0] got, want;
      do_clr();
      bus.en = 2'b11;
      for (int j = 1; j <= 16; j++) begin
         exp_q.push_back({tog4(j)[1], tog4(j)[1], tog4(j)[0], tog4(j)[0]});
         @(posedge CLKin);
         #1;
         got  = {bus.clk_out, bus.tick};
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL toggle j=%0d got=%b want=%b", j, got, want);
         end
      end
   endtask

   task automatic test_pulse();
      logic [3:0] got, want;
      logic       p;
      do_clr();
      bus.en   = 2'b11;
      bus.mode = 2'b10;
      for (int j = 1; j <= 16; j++) begin
         idle_inputs();
         if (j == 6) begin
            bus.load     = 1'b1;
            bus.load_ch  = 1'b1;
            bus.load_div = 8'd0;
         end
         p = (j >= 9) ? 1'b1 : (j % 4 == 0);
         exp_q.push_back({p, tog4(j)[1], p, tog4(j)[0]});
         @(posedge CLKin);
         #1;
         got  = {bus.clk_out, bus.tick};
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL pulse j=%0d got=%b want=%b", j, got, want);
         end
      end
   endtask

   task automatic test_mode_switch();
      logic [3:0] got, want;
      logic       c1, t1;
      do_clr();
      bus.en = 2'b11;
      for (int j = 1; j <= 12; j++) begin
         bus.mode = (j >= 6) ? 2'b10 : 2'b00;
         t1 = (j % 4 == 0);
         c1 = (j >= 6) ? t1 : tog4(j)[1];
         exp_q.push_back({c1, tog4(j)[1], t1, tog4(j)[0]});
         @(posedge CLKin);
         #1;
         got  = {bus.clk_out, bus.tick};
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL mode_switch j=%0d got=%b want=%b", j, got, want);
         end
      end
   endtask

   task automatic test_shadow();
      logic [3:0] got, want;
      logic       t0, c0;
      do_clr();
      bus.en = 2'b11;
      for (int j = 1; j <= 24; j++) begin
         idle_inputs();
         if (j == 1 || j == 3) begin
            bus.load     = 1'b1;
            bus.load_ch  = 1'b0;
            bus.load_div = (j == 1) ? 8'd9 : 8'd5;
         end
         t0 = (j >= 4) && ((j - 4) % 6 == 0);
         c0 = (j >= 4) && ((((j - 4) / 6) % 2) == 0);
         exp_q.push_back({tog4(j)[1], c0, tog4(j)[0], t0});
         @(posedge CLKin);
         #1;
         got  = {bus.clk_out, bus.tick};
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL shadow j=%0d got=%b want=%b", j, got, want);
         end
      end
   endtask

   task automatic test_sync();
      logic [3:0] got, want;
      logic [3:0] pre [1:10];
      int         s;
      pre = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1100,
              4'b1100, 4'b1100, 4'b0110, 4'b0100, 4'b0001};
      do_clr();
      bus.en = 2'b11;
      for (int j = 1; j <= 20; j++) begin
         bus.en   = (j == 6 || j == 7) ? 2'b10 : 2'b11;
         bus.sync = (j == 11);
         if (j <= 10) begin
            want = pre[j];
         end else begin
            s    = j - 11;
            want = {tog4(s)[1], tog4(s)[1], tog4(s)[0], tog4(s)[0]};
         end
         exp_q.push_back(want);
         @(posedge CLKin);
         #1;
         got  = {bus.clk_out, bus.tick};
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL sync j=%0d got=%b want=%b", j, got, want);
         end
      end
      bus.sync = 1'b0;
   endtask

   task automatic test_disabled_load();
      logic [3:0] got, want;
      logic       t0, c0;
      do_clr();
      for (int j = 1; j <= 16; j++) begin
         idle_inputs();
         bus.en = (j >= 4 && j <= 6) ? 2'b10 : 2'b11;
         if (j == 4) begin
            bus.load     = 1'b1;
            bus.load_ch  = 1'b0;
            bus.load_div = 8'd1;
         end
         t0 = (j >= 8) && ((j - 8) % 2 == 0);
         c0 = (j >= 8) && ((((j - 8) / 2) % 2) == 0);
         exp_q.push_back({tog4(j)[1], c0, tog4(j)[0], t0});
         @(posedge CLKin);
         #1;
         got  = {bus.clk_out, bus.tick};
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL disabled_load j=%0d got=%b want=%b", j, got, want);
         end
      end
   endtask

   task automatic test_clr_override();
      logic [3:0] got, want;
      do_clr();
      bus.en = 2'b11;
      repeat (2) @(posedge CLKin);
      #1;
      clr          = 1'b1;
      bus.load     = 1'b1;
      bus.load_ch  = 1'b0;
      bus.load_div = 8'd7;
      bus.sync     = 1'b1;
      exp_q.push_back(4'b0000);
      @(posedge CLKin);
      #1;
      clr = 1'b0;
      idle_inputs();
      got  = {bus.clk_out, bus.tick};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL clr_override_now got=%b want=%b", got, want);
      end
      for (int j = 1; j <= 12; j++) begin
         exp_q.push_back({tog4(j)[1], tog4(j)[1], tog4(j)[0], tog4(j)[0]});
         @(posedge CLKin);
         #1;
         got  = {bus.clk_out, bus.tick};
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL clr_override j=%0d got=%b want=%b", j, got, want);
         end
      end
   endtask

   initial begin
      clr = 1'b1;
      idle_inputs();
      bus.en   = 2'b00;
      bus.mode = 2'b00;
      test_reset();
      test_toggle();
      test_pulse();
      test_mode_switch();
      test_shadow();
      test_sync();
      test_disabled_load();
      test_clr_override();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel programmable clock divider and tick generator, the parametrised successor to the fixed 25,000,000-count single-output divider. Each of `CHANNELS` independent channels divides `CLKin` by a runtime-loadable divisor. Each channel produces either a 50 % square wave or a one-cycle enable pulse, plus a one-cycle `tick` strobe for downstream logic. All channels can be restarted phase-aligned. The block feeds display scan, debounce and game-timer logic from the single board clock.

## Interface
- `CHANNELS`, default 4: number of independent divider channels (1..16).
- `CNT_W`, default 32: width of the counters and divisors.
- `DEFAULT_DIV`, default 25000000: divisor loaded into every channel on reset.
- `CLKin  in  1`: the only clock; all logic is on its rising edge.
- `clr  in  1`: synchronous, active-high reset.
- `en  in  CHANNELS`: per-channel count enable.
- `mode  in  CHANNELS`: per-channel output mode; 0 = toggle (square wave), 1 = pulse.
- `load  in  1`: one-cycle strobe that writes `load_div` into the shadow divisor of channel `load_ch`.
- `load_ch  in  max(1,$clog2(CHANNELS))`: target channel for `load`.
- `load_div  in  CNT_W`: new divisor value.
- `sync  in  1`: one-cycle strobe that restarts all channels phase-aligned.
- `clk_out  out  CHANNELS`: registered divided output per channel.
- `tick  out  CHANNELS`: registered one-cycle strobe per channel, asserted at each terminal count.

## Operation
Per-channel state: `cnt[CNT_W]`, active divisor `div`, shadow divisor `shd`, pending flag `pnd`, output register, tick register.

- **Reset (`clr`=1).** `cnt`=0, `div`=`shd`=`DEFAULT_DIV`, `pnd`=0, `clk_out`=0, `tick`=0 for all channels. `clr` overrides `load` and `sync`.
- **Counting.** When `en[i]`=1 and `cnt`≠`div`: `cnt`++.
- **Terminal count.** When `en[i]`=1 and `cnt`==`div`:
  - `cnt`←0 and `tick[i]`←1 for one cycle.
  - Toggle mode: `clk_out[i]` inverts. Pulse mode: `clk_out[i]`←1 for one cycle.
  - If `pnd`=1, then `div`←`shd` and `pnd`←0 on the same edge, so the new period starts cleanly.
- **Non-terminal cycles.** `tick`=0. In pulse mode `clk_out`=0. In toggle mode `clk_out` holds.
- **Disabled (`en[i]`=0).** `cnt` holds, `tick`=0. Toggle-mode `clk_out` holds its level; pulse-mode `clk_out`=0. A pending `shd` is applied immediately: `div`←`shd`, `pnd`←0. If `cnt`>new `div`, then `cnt`←0.
- **Load.** `load`=1 writes `shd[load_ch]`←`load_div` and sets `pnd`. If `load_ch`≥`CHANNELS`, the strobe is ignored. A second load before the terminal count overwrites `shd`; only the last value is applied.
- **Sync.** `sync`=1 acts on all channels: `cnt`←0, `clk_out`←0, `tick`←0, and any pending `shd` is applied. When `load` and `sync` arrive in the same cycle, the freshly loaded value is the one applied.
- **Mode change.** A change takes effect on the next edge. Switching toggle→pulse forces `clk_out` to 0 on the next non-terminal cycle.
- **Period rule.** Terminal count occurs every `div`+1 enabled cycles.
  - Toggle period is 2·(`div`+1) cycles.
  - `div`=0 in toggle mode gives `CLKin`/2.
  - `div`=0 in pulse mode gives `clk_out` and `tick` held at 1 while enabled.
- **Arithmetic.** Unsigned `CNT_W`-bit arithmetic. `cnt` never exceeds `div`, so no wrap-around occurs.

## Timing
- All outputs are registered, with zero combinational paths from inputs to outputs.
- After `clr` falls (last `clr`=1 edge is E0, `cnt`=0 after E0), with `en`=1, the first terminal compare is true after edge E`div`. `tick` and the `clk_out` change are visible after edge E`div`+1.
- `load` to the shadow register: 1 cycle. Shadow to active: at the next terminal count, or 1 cycle when the channel is disabled or `sync` is asserted.
- After `sync` at edge S, channels with equal `div` produce coincident `tick`s at edge S+`div`+1, and every `div`+1 cycles thereafter.
- `clr` asserted mid-period discards the count and pending loads on that edge.

## Test plan
1. `DEFAULT_DIV`=3, `CHANNELS`=2. Drive `clr` for 2 cycles, then `en`=2'b11, `mode`=2'b00. Required: `tick` high 1 cycle in every 4; `clk_out` period 8 cycles at 50 % duty; first `tick` 4 cycles after `clr` falls.
2. Channel 1 in pulse mode with `div`=3. Required: `clk_out[1]`==`tick[1]` with a 1-in-4 pattern. Load `load_div`=0 → after the next terminal count, `clk_out[1]` stays constantly 1.
3. Mid-period, `load` ch0 with 9, then `load` ch0 with 5 two cycles later. Required: the current period still completes at 4 cycles; subsequent periods are 6 cycles; 9 is never applied.
4. Offset the channels by toggling `en[0]` low for 2 cycles, then assert `sync`. Required: both `clk_out`=0 the next cycle, and both `tick`s coincide 4 cycles later.
5. With `en[0]`=0 and `cnt`=3, `load` ch0 with 1. Required: `div` updates in 1 cycle and `cnt` resets to 0. Re-enable → `tick` every 2 cycles.
6. Assert `clr` concurrently with `load` and `sync`, mid-count. Required: all outputs 0, `div`=`DEFAULT_DIV`, and the load is discarded (period 4 resumes).
